// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Brief    : Next-PC selection for branches, CALL and RET with a circular
//             return-address stack; memory return value used when it is empty.
//  Revision : 1.0
// ============================================================================
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter int               RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       branch_op,
  input  logic [2:0]       stack_op,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cond_val,
  input  logic [WIDTH-1:0] mem_ret,
  input  logic             ras_flush,
  output logic [WIDTH-1:0] pc_out,
  output logic             taken,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             illegal_op
);

  localparam int c_ptr_w = $clog2(RAS_DEPTH);
  localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(RAS_DEPTH);

  localparam logic [2:0] c_br_none = 3'b000;
  localparam logic [2:0] c_br_br   = 3'b001;
  localparam logic [2:0] c_br_bpl  = 3'b010;
  localparam logic [2:0] c_br_bmi  = 3'b011;
  localparam logic [2:0] c_br_bz   = 3'b100;
  localparam logic [2:0] c_br_bnz  = 3'b101;

  localparam logic [2:0] c_st_call = 3'b011;
  localparam logic [2:0] c_st_ret  = 3'b100;

  logic [WIDTH-1:0]   r_pc;
  logic               r_taken;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_top;
  logic [WIDTH-1:0]   r_ras [RAS_DEPTH];
  logic               r_overflow;
  logic               r_underflow;
  logic               r_illegal;

  logic [WIDTH-1:0]   w_seq;
  logic               w_cond;
  logic               w_cond_zero;
  logic               w_cond_neg;
  logic               w_br_illegal;
  logic [c_cnt_w-1:0] w_cnt_eff;
  logic [c_ptr_w-1:0] w_top_eff;
  logic [c_ptr_w-1:0] w_top_inc;
  logic [c_ptr_w-1:0] w_top_dec;
  logic [WIDTH-1:0]   w_pc_nxt;
  logic               w_taken_nxt;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic [c_ptr_w-1:0] w_top_nxt;
  logic               w_push;
  logic               w_set_ovf;
  logic               w_set_unf;

  // Signed condition evaluation on cond_val
  always_comb begin
    w_cond_zero  = (cond_val == '0);
    w_cond_neg   = cond_val[WIDTH-1];
    w_cond       = 1'b0;
    w_br_illegal = 1'b0;
    case (branch_op)
      c_br_br:  w_cond = 1'b1;
      c_br_bpl: w_cond = !w_cond_neg && !w_cond_zero;
      c_br_bmi: w_cond = w_cond_neg;
      c_br_bz:  w_cond = w_cond_zero;
      c_br_bnz: w_cond = !w_cond_zero;
      c_br_none: w_cond = 1'b0;
      default:  w_br_illegal = 1'b1;
    endcase
  end

  // A flush in the same cycle makes the RAS look empty to the current op
  always_comb begin
    w_seq     = r_pc + WIDTH'(1);
    w_cnt_eff = ras_flush ? '0 : r_count;
    w_top_eff = ras_flush ? '0 : r_top;
    w_top_inc = w_top_eff + c_ptr_w'(1);
    w_top_dec = w_top_eff - c_ptr_w'(1);

    w_pc_nxt    = w_seq;
    w_taken_nxt = 1'b0;
    w_count_nxt = w_cnt_eff;
    w_top_nxt   = w_top_eff;
    w_push      = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;

    if (branch_op != c_br_none) begin
      if (!w_br_illegal) begin
        w_taken_nxt = w_cond;
        w_pc_nxt    = w_cond ? target : w_seq;
      end
    end else begin
      case (stack_op)
        c_st_call: begin
          w_pc_nxt    = target;
          w_taken_nxt = 1'b1;
          w_push      = 1'b1;
          w_top_nxt   = w_top_inc;
          // When full the oldest slot is the one overwritten; count saturates
          if (w_cnt_eff == c_cnt_full) begin
            w_set_ovf = 1'b1;
          end else begin
            w_count_nxt = w_cnt_eff + c_cnt_w'(1);
          end
        end
        c_st_ret: begin
          w_taken_nxt = 1'b1;
          if (w_cnt_eff != '0) begin
            w_pc_nxt    = r_ras[w_top_eff];
            w_top_nxt   = w_top_dec;
            w_count_nxt = w_cnt_eff - c_cnt_w'(1);
          end else begin
            w_pc_nxt  = mem_ret;
            w_set_unf = 1'b1;
          end
        end
        default: begin
          w_pc_nxt    = w_seq;
          w_taken_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_taken     <= 1'b0;
      r_count     <= '0;
      r_top       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (en) begin
      r_pc        <= w_pc_nxt;
      r_taken     <= w_taken_nxt;
      r_count     <= w_count_nxt;
      r_top       <= w_top_nxt;
      r_overflow  <= r_overflow  | w_set_ovf;
      r_underflow <= r_underflow | w_set_unf;
      r_illegal   <= r_illegal   | w_br_illegal;
    end
  end

  // Entry storage carries no reset; only count/top define validity
  always_ff @(posedge clk) begin
    if (rst && en && w_push) begin
      r_ras[w_top_inc] <= w_seq;
    end
  end

  assign pc_out        = r_pc;
  assign taken         = r_taken;
  assign ras_empty     = (r_count == '0);
  assign ras_full      = (r_count == c_cnt_full);
  assign ras_overflow  = r_overflow;
  assign ras_underflow = r_underflow;
  assign illegal_op    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Brief    : Directed plus randomized bench for pc_sequencer against a
//             queue-based reference model of the return-address stack.
//  Revision : 1.0
// ============================================================================
module tb_pc_sequencer;

  localparam int W = 32;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [2:0]   branch_op;
  logic [2:0]   stack_op;
  logic [W-1:0] target;
  logic [W-1:0] cond_val;
  logic [W-1:0] mem_ret;
  logic         ras_flush;
  logic [W-1:0] pc_out;
  logic         taken;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_overflow;
  logic         ras_underflow;
  logic         illegal_op;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: the RAS is a bounded queue of return addresses
  logic [W-1:0] m_pc;
  bit           m_taken;
  bit           m_ovf;
  bit           m_unf;
  bit           m_ill;
  logic [W-1:0] m_ras[$];

  pc_sequencer #(.WIDTH(W), .RAS_DEPTH(D), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .branch_op     (branch_op),
    .stack_op      (stack_op),
    .target        (target),
    .cond_val      (cond_val),
    .mem_ret       (mem_ret),
    .ras_flush     (ras_flush),
    .pc_out        (pc_out),
    .taken         (taken),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    pc_out,              m_pc);
    check({tag, ".taken"}, W'(taken),           W'(m_taken));
    check({tag, ".empty"}, W'(ras_empty),       W'(m_ras.size() == 0));
    check({tag, ".full"},  W'(ras_full),        W'(m_ras.size() == D));
    check({tag, ".ovf"},   W'(ras_overflow),    W'(m_ovf));
    check({tag, ".unf"},   W'(ras_underflow),   W'(m_unf));
    check({tag, ".ill"},   W'(illegal_op),      W'(m_ill));
  endtask

  task automatic model_reset();
    m_pc = '0; m_taken = 0; m_ovf = 0; m_unf = 0; m_ill = 0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [W-1:0] seq;
    bit t;
    if (!en) return;
    seq = m_pc + 1;
    if (ras_flush) m_ras.delete();
    if (branch_op != 3'd0) begin
      case (branch_op)
        3'd1: t = 1;
        3'd2: t = ($signed(cond_val) > 0);
        3'd3: t = ($signed(cond_val) < 0);
        3'd4: t = (cond_val == 0);
        3'd5: t = (cond_val != 0);
        default: begin t = 0; m_ill = 1; end
      endcase
      m_pc = t ? target : seq;
      m_taken = t;
    end else if (stack_op == 3'd3) begin
      if (m_ras.size() == D) begin
        m_ovf = 1;
        void'(m_ras.pop_front());
      end
      m_ras.push_back(seq);
      m_pc = target;
      m_taken = 1;
    end else if (stack_op == 3'd4) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc = mem_ret;
        m_unf = 1;
      end
      m_taken = 1;
    end else begin
      m_pc = seq;
      m_taken = 0;
    end
  endtask

  task automatic set_in(input bit e, input logic [2:0] b, input logic [2:0] s,
                        input logic [W-1:0] t, input logic [W-1:0] c,
                        input logic [W-1:0] m, input bit f);
    en = e; branch_op = b; stack_op = s; target = t; cond_val = c; mem_ret = m; ras_flush = f;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Called 1 time unit after a rising edge; asserts reset mid-cycle
  task automatic do_reset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 3'd0, 3'd0, '0, '0, '0, 0);
    @(posedge clk);
    #1;
    do_reset("rst0");
    check("rst_pc", pc_out, 32'd0);

    for (int i = 0; i < 3; i++) begin
      set_in(1, 3'd0, 3'd0, '0, '0, '0, 0);
      step("seq");
    end
    check("seq3", pc_out, 32'd3);

    // Signed branches from pc=10
    set_in(1, 3'd1, 3'd0, 32'd10, '0, '0, 0); step("br10");
    set_in(1, 3'd2, 3'd0, 32'd40, 32'd0, '0, 0); step("bpl0");
    check("bpl_zero", pc_out, 32'd11);
    set_in(1, 3'd1, 3'd0, 32'd10, '0, '0, 0); step("br10");
    set_in(1, 3'd2, 3'd0, 32'd40, 32'd5, '0, 0); step("bpl5");
    check("bpl_pos", pc_out, 32'd40);
    set_in(1, 3'd1, 3'd0, 32'd10, '0, '0, 0); step("br10");
    set_in(1, 3'd3, 3'd0, 32'd40, 32'hFFFF_FFFF, '0, 0); step("bmi");
    check("bmi_neg", pc_out, 32'd40);
    set_in(1, 3'd1, 3'd0, 32'd10, '0, '0, 0); step("br10");
    set_in(1, 3'd5, 3'd0, 32'd40, 32'd0, '0, 0); step("bnz0");
    check("bnz_zero_taken", W'(taken), 32'd0);
    set_in(1, 3'd4, 3'd0, 32'd60, 32'd0, '0, 0); step("bz0");

    // Call/return nesting
    set_in(1, 3'd1, 3'd0, 32'd5, '0, '0, 0); step("br5");
    set_in(1, 3'd0, 3'd3, 32'd100, '0, '0, 0); step("call100");
    set_in(1, 3'd0, 3'd3, 32'd200, '0, '0, 0); step("call200");
    set_in(1, 3'd0, 3'd4, '0, '0, 32'd999, 0); step("ret1");
    check("ret_101", pc_out, 32'd101);
    step("ret2");
    check("ret_6", pc_out, 32'd6);
    check("nest_empty", W'(ras_empty), 32'd1);

    // Underflow
    set_in(1, 3'd0, 3'd4, '0, '0, 32'd77, 0); step("unf");
    check("unf_pc", pc_out, 32'd77);
    check("unf_flag", W'(ras_underflow), 32'd1);

    // Overflow: nine nested calls, then nine returns
    for (int i = 0; i < 9; i++) begin
      set_in(1, 3'd0, 3'd3, 32'd1000 + 32'(16 * i), '0, '0, 0);
      step("ovf_call");
    end
    check("ovf_flag", W'(ras_overflow), 32'd1);
    check("ovf_full", W'(ras_full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      set_in(1, 3'd0, 3'd4, '0, '0, 32'h1234, 0);
      step("ovf_ret");
    end
    check("ovf_ret8", pc_out, 32'd1000 + 32'(16 * 0) + 32'd1);
    step("ovf_ret9");
    check("ovf_ret9_mem", pc_out, 32'h1234);

    // Priority: branch wins over CALL and leaves RAS alone
    set_in(1, 3'd1, 3'd3, 32'd300, '0, '0, 0); step("prio");
    check("prio_pc", pc_out, 32'd300);

    // Stall with CALL held
    set_in(1, 3'd0, 3'd3, 32'd400, '0, '0, 0); step("call400");
    for (int i = 0; i < 3; i++) begin
      set_in(0, 3'd0, 3'd3, 32'd999, '0, '0, 1);
      step("stall");
    end
    check("stall_pc", pc_out, 32'd400);

    // Flush combined with CALL, then RET
    set_in(1, 3'd1, 3'd0, 32'd20, '0, '0, 0); step("br20");
    set_in(1, 3'd0, 3'd3, 32'd500, '0, '0, 1); step("flushcall");
    check("flush_notempty", W'(ras_empty), 32'd0);
    set_in(1, 3'd0, 3'd4, '0, '0, 32'd55, 0); step("flushret");
    check("flush_ret21", pc_out, 32'd21);
    check("flush_empty", W'(ras_empty), 32'd1);

    // Flush combined with RET while non-empty
    set_in(1, 3'd0, 3'd3, 32'd600, '0, '0, 0); step("call600");
    set_in(1, 3'd0, 3'd4, '0, '0, 32'd88, 1); step("flushret_mem");
    check("flushret_pc", pc_out, 32'd88);

    // PC wrap and illegal branch
    set_in(1, 3'd1, 3'd0, 32'hFFFF_FFFF, '0, '0, 0); step("brmax");
    set_in(1, 3'd0, 3'd0, '0, '0, '0, 0); step("wrap");
    check("wrap_pc", pc_out, 32'd0);
    set_in(1, 3'd6, 3'd3, 32'd700, '0, '0, 0); step("ill");
    check("ill_flag", W'(illegal_op), 32'd1);

    do_reset("rst1");

    // Randomized phase
    for (int i = 0; i < 2000; i++) begin
      logic [2:0]   b;
      logic [2:0]   s;
      logic [W-1:0] c;
      b = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(1, (i < 1500) ? 5 : 7));
      s = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) s = ($urandom_range(0, 2) != 0) ? 3'd3 : 3'd4;
      case ($urandom_range(0, 5))
        0: c = '0;
        1: c = 32'd1;
        2: c = 32'hFFFF_FFFF;
        3: c = 32'h8000_0000;
        4: c = 32'h7FFF_FFFF;
        default: c = $urandom;
      endcase
      set_in($urandom_range(0, 9) != 0, b, s, $urandom, c, $urandom,
             $urandom_range(0, 24) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
